// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide unit.
// Holds the op encoding, FSM state type, iteration count and a helper.
package muldiv_pkg;

  localparam int MULDIV_ITER  = 32;
  localparam int MULDIV_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // Unsigned magnitude; 0x8000_0000 stays 0x8000_0000.
  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// ctrl_bus_if: CPU control bus carrying the clock and sync reset.
// Ports: clk, reset; modport central consumes both.
interface ctrl_bus_if;

  logic clk;
  logic reset;

  modport central (
    input clk,
    input reset
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add or restore-subtract step.
// Ports: mode_i (1=divide), acc_i, opnd_i in; acc_o next accumulator.
module muldiv_step (
  input  logic        mode_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] rem33;
  logic [32:0] diff;

  // Multiply: acc = {partial, multiplier}; add on LSB, shift right
  // keeping the carry as the new top bit.
  assign sum = {1'b0, acc_i[63:32]}
             + {1'b0, (acc_i[0] ? opnd_i : 32'd0)};

  // Divide: acc = {remainder, dividend/quotient}; shift one
  // dividend bit into a 33-bit remainder and try the subtract.
  assign rem33 = {acc_i[63:32], acc_i[31]};
  assign diff  = rem33 - {1'b0, opnd_i};

  always_comb begin
    acc_o = {sum, acc_i[31:1]};
    if (mode_i) begin
      if (!diff[32]) begin
        acc_o = {diff[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {rem33[31:0], acc_i[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Ports: ctrl_bus (clk, reset), start, op, rs_data, rt_data,
// write_hi, write_lo in; busy, done, hi, lo out.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  ctrl_bus_if.central ctrl_bus,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        write_hi,
  input  logic        write_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_FIX  = ST_FIX;

  localparam logic [MULDIV_CNT_W-1:0] CNT_LAST =
    MULDIV_CNT_W'(ITER - 1);

  logic clk;
  logic rst;

  assign clk = ctrl_bus.clk;
  assign rst = ctrl_bus.reset;

  logic [1:0]              state_q, state_d;
  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]             acc_q, acc_d;
  logic [31:0]             opnd_q, opnd_d;
  logic                    div_q, div_d;
  logic                    neg_q, neg_d;
  logic                    rneg_q, rneg_d;
  logic                    dz_q, dz_d;
  logic [31:0]             hi_q, hi_d;
  logic [31:0]             lo_q, lo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic        is_div;
  logic        is_sgn;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [63:0] step_acc;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign rs_mag = mag32(rs_data, is_sgn);
  assign rt_mag = mag32(rt_data, is_sgn);

  muldiv_step u_step (
    .mode_i (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Divide by zero leaves quotient all-ones and remainder equal to
  // the dividend magnitude; suppressing only the quotient negation
  // yields LO=0xFFFF_FFFF and HI=original rs_data.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = (neg_q && !dz_q) ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = is_div;
          dz_d    = is_div && (rt_data == 32'd0);
          neg_d   = is_sgn && (rs_data[31] ^ rt_data[31]);
          rneg_d  = is_sgn && is_div && rs_data[31];
          if (is_div) begin
            acc_d  = {32'd0, rs_mag};
            opnd_d = rt_mag;
          end else begin
            acc_d  = {32'd0, rt_mag};
            opnd_d = rs_mag;
          end
        end else begin
          if (write_hi) hi_d = rs_data;
          if (write_lo) lo_d = rs_data;
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
